pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM in the single-cycle RISC-V core.
- Holds the PC and drives the ROM word address.
- Selects the next PC (sequential, branch, jal, jalr) from Ctrl/EXT/RF/ALU results.
- Provides free-run / pause / single-step / halt control for board debugging.
- Emits instr_valid, which gates regWrite/memWrite downstream.
- Provides pc_plus4 for the WD_CTRL_PC writeback path and a retired-instruction counter for the seg7 display.

Parameters:
XLEN, 32, datapath width
ROM_AW, 7, instruction ROM word-address width
INSTR_NUM, 16, number of valid instruction words; word indices 0..INSTR_NUM-1
RESET_PC, 0, byte address loaded on reset; must be word-aligned and inside the valid range

Ports:
clk  in  1  CPU clock (divided CLK_CPU)
rst  in  1  synchronous reset, active-high
run_en  in  1  1 = free-run, 0 = pause (board switch)
step_req  in  1  single-step request level; the rising edge is used
halt_req  in  1  enter HALT; only rst leaves HALT
branch_take  in  1  conditional branch resolved taken (Ctrl & ALU zero)
jal  in  1  current instruction is jal
jalr  in  1  current instruction is jalr
imm  in  XLEN  sign-extended immediate from EXT, as a byte offset
rs1_val  in  XLEN  RF read data 1
pc  out  XLEN  current PC, byte address
rom_addr  out  ROM_AW  pc[ROM_AW+1:2]
pc_plus4  out  XLEN  pc + 4, combinational
instr_valid  out  1  current instruction commits this cycle
state  out  2  00 RUN, 01 PAUSE, 10 STEP, 11 HALT
misalign_err  out  1  sticky; redirect target not word-aligned
range_err  out  1  sticky; redirect target word index >= INSTR_NUM
retire_cnt  out  32  count of instr_valid cycles, wraps at 2^32

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset values:
  - pc = RESET_PC; state = PAUSE
  - misalign_err = 0, range_err = 0, retire_cnt = 0
  - step edge register = 0
  - instr_valid = 0 during reset
- Step edge detection:
  - step_d <= step_req every cycle.
  - step_edge = step_req & ~step_d.
  - A held step_req produces exactly one edge.
- FSM transitions (halt_req = 1 overrides every transition: next state HALT):
  - RUN: run_en = 0 -> PAUSE; otherwise stay in RUN.
  - PAUSE: run_en = 1 -> RUN (takes priority over step_edge, and the edge is discarded); else step_edge -> STEP; else stay in PAUSE.
  - STEP: -> PAUSE unconditionally, after exactly one cycle.
  - HALT: stay in HALT; only rst exits.
- advance = ((state == RUN & run_en) | state == STEP) & ~halt_req.
- Target select, priority jalr > jal > branch_take > sequential:
  - jalr: (rs1_val + imm) & ~1
  - jal or branch: pc + imm
  - sequential: pc + 4
  - All additions are modulo 2^XLEN.
- Fault check, applied only when advance = 1 and the source is a redirect:
  - target[1:0] != 0 -> set misalign_err, fault.
  - target[XLEN-1:2] >= INSTR_NUM -> set range_err, fault.
  - Both flags may be set in the same cycle.
  - On fault: pc holds, instr_valid = 0, next state = HALT.
- Sequential wrap: if the word index of pc + 4 is >= INSTR_NUM, next pc = RESET_PC. This is not a fault.
- instr_valid = advance & ~fault. It is combinational, valid in the same cycle as the instruction.
- When instr_valid = 1: pc <= selected target and retire_cnt <= retire_cnt + 1.
- When advance = 0: pc, retire_cnt and both error flags hold.
- Error flags clear only on rst.
- rst asserted mid-STEP or in HALT returns the block to PAUSE at RESET_PC on the next edge.

Test Plan:
- Reset, run_en = 1, no redirects, 20 cycles -> state PAUSE then RUN; pc steps 0,4,...,60,0,4,...; wraps at 60 -> 0; retire_cnt = 19 after cycle 20 (first cycle in PAUSE); instr_valid = 0 in PAUSE.
- run_en = 0, step_req held high 5 cycles then low, repeated twice -> two STEP cycles only; pc 0 -> 4 -> 8; retire_cnt = 2; state returns to PAUSE after each step.
- At pc = 8: branch_take = 1, imm = -8 -> pc = 0. Then jal = 1, imm = 12 -> pc = 12. Then jalr = 1, rs1_val = 21, imm = 3 -> target 24, pc = 24. With jal and branch_take both set, jal's target is used.
- At pc = 8: jal = 1, imm = 2 -> misalign_err = 1, pc stays 8, instr_valid = 0, state HALT. Later run_en/step_req activity leaves pc at 8.
- At pc = 0: branch_take = 1, imm = 64 -> range_err = 1, HALT. rst = 1 for 1 cycle -> pc = 0, state PAUSE, both errors 0, retire_cnt = 0.
- In RUN, halt_req = 1 for one cycle at pc = 12 -> instr_valid = 0 that cycle, pc stays 12, state HALT persists after halt_req drops.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select and debug run control for the instruction ROM
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   run_en, step_req, halt_req    board debug controls (free-run, single-step, halt)
//   branch_take, jal, jalr        redirect requests from the decoder / ALU
//   imm, rs1_val                  byte offset from EXT, RF read data 1
//   pc, rom_addr, pc_plus4        current PC, ROM word address, PC + 4
//   instr_valid                   current instruction commits this cycle
//   state                         00 RUN, 01 PAUSE, 10 STEP, 11 HALT
//   misalign_err, range_err       sticky redirect-target fault flags
//   retire_cnt                    committed-instruction counter
module pc_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              ROM_AW    = 7,
    parameter int              INSTR_NUM = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              branch_take,
    input  logic              jal,
    input  logic              jalr,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_val,
    output logic [XLEN-1:0]   pc,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              instr_valid,
    output logic [1:0]        state,
    output logic              misalign_err,
    output logic              range_err,
    output logic [31:0]       retire_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_PAUSE = 2'b01,
        S_STEP  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [XLEN-3:0] INSTR_LIMIT = (XLEN-2)'(INSTR_NUM);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            step_d;
    logic            step_edge;
    logic            advance;
    logic            redirect;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] seq_tgt;
    logic [XLEN-1:0] next_pc;
    logic            tgt_misalign;
    logic            tgt_range;
    logic            fault;

    assign step_edge = step_req & ~step_d;
    assign advance   = (((state_q == S_RUN) & run_en) | (state_q == S_STEP)) & ~halt_req;
    assign redirect  = jalr | jal | branch_take;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign jalr_sum  = rs1_val + imm;
    // jalr clears bit 0 of the sum; jal and branch share pc-relative targets
    assign redir_tgt = jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_q + imm);

    // Running off the end of the program image restarts it rather than faulting
    assign seq_tgt   = (pc_plus4[XLEN-1:2] >= INSTR_LIMIT) ? RESET_PC : pc_plus4;
    assign next_pc   = redirect ? redir_tgt : seq_tgt;

    assign tgt_misalign = redir_tgt[1:0] != 2'b00;
    assign tgt_range    = redir_tgt[XLEN-1:2] >= INSTR_LIMIT;
    assign fault        = advance & redirect & (tgt_misalign | tgt_range);

    // Gated with rst so nothing downstream commits while the block is being reset
    assign instr_valid = advance & ~fault & ~rst;

    assign pc       = pc_q;
    assign rom_addr = pc_q[ROM_AW+1:2];
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            state_q      <= S_PAUSE;
            step_d       <= 1'b0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
            retire_cnt   <= '0;
        end else begin
            step_d <= step_req;

            if (fault) begin
                misalign_err <= misalign_err | tgt_misalign;
                range_err    <= range_err | tgt_range;
            end

            if (advance & ~fault) begin
                pc_q       <= next_pc;
                retire_cnt <= retire_cnt + 32'd1;
            end

            if (halt_req | fault) begin
                state_q <= S_HALT;
            end else begin
                case (state_q)
                    S_RUN:   if (!run_en) state_q <= S_PAUSE;
                    // run_en wins over a pending step edge, which is then dropped
                    S_PAUSE: if (run_en) state_q <= S_RUN;
                             else if (step_edge) state_q <= S_STEP;
                    S_STEP:  state_q <= S_PAUSE;
                    default: state_q <= S_HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, run_en, step_req, halt_req, branch_take, jal, jalr;
    logic [31:0] imm, rs1_val;
    logic [31:0] pc, pc_plus4, retire_cnt;
    logic [6:0]  rom_addr;
    logic        instr_valid, misalign_err, range_err;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req), .halt_req(halt_req),
        .branch_take(branch_take), .jal(jal), .jalr(jalr), .imm(imm), .rs1_val(rs1_val),
        .pc(pc), .rom_addr(rom_addr), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .state(state), .misalign_err(misalign_err), .range_err(range_err),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic run, input logic st, input logic h,
                          input logic br, input logic jl, input logic jr,
                          input logic [31:0] im, input logic [31:0] rs);
        rst = r; run_en = run; step_req = st; halt_req = h;
        branch_take = br; jal = jl; jalr = jr; imm = im; rs1_val = rs;
    endtask

    // Directed vectors: inputs for one cycle, instr_valid expected in that cycle,
    // and register values expected after the following clock edge.
    typedef struct {
        logic        rst, run, step, halt, br, jl, jr;
        logic [31:0] imm, rs1;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        mis, rng;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic run, logic st, logic h, logic br, logic jl,
                                logic jr, logic [31:0] im, logic [31:0] rs, logic v,
                                logic [31:0] p, logic [1:0] s, logic m, logic g,
                                logic [31:0] c);
        vec_t x;
        x.rst = r; x.run = run; x.step = st; x.halt = h; x.br = br; x.jl = jl; x.jr = jr;
        x.imm = im; x.rs1 = rs; x.valid = v; x.pc = p; x.st = s; x.mis = m; x.rng = g;
        x.cnt = c;
        return x;
    endfunction

    // Behavioural reference: PC as a byte address, program of 16 words at 0..60.
    logic [31:0] m_pc, m_cnt;
    int          m_state;          // 0 RUN, 1 PAUSE, 2 STEP, 3 HALT
    bit          m_mis, m_rng, m_prev_step;
    bit          e_valid, e_fault, e_bad_m, e_bad_r;
    logic [31:0] e_target;

    task automatic model_eval();
        bit adv, redir;
        adv   = !rst && !halt_req && ((m_state == 0 && run_en) || m_state == 2);
        redir = jalr || jal || branch_take;
        if (jalr)                   e_target = (rs1_val + imm) & ~32'd1;
        else if (jal || branch_take) e_target = m_pc + imm;
        else begin
            e_target = m_pc + 32'd4;
            if (e_target / 4 >= 16) e_target = 32'd0;
        end
        e_bad_m = redir && (e_target % 4 != 0);
        e_bad_r = redir && (e_target / 4 >= 16);
        e_fault = adv && (e_bad_m || e_bad_r);
        e_valid = adv && !e_fault;
    endtask

    task automatic model_clock();
        if (rst) begin
            m_pc = 0; m_state = 1; m_mis = 0; m_rng = 0; m_cnt = 0; m_prev_step = 0;
        end else begin
            if (e_valid) begin m_pc = e_target; m_cnt = m_cnt + 1; end
            if (e_fault) begin m_mis = m_mis | e_bad_m; m_rng = m_rng | e_bad_r; end
            if (halt_req || e_fault) m_state = 3;
            else if (m_state == 0) m_state = run_en ? 0 : 1;
            else if (m_state == 1) m_state = run_en ? 0 : ((step_req && !m_prev_step) ? 2 : 1);
            else if (m_state == 2) m_state = 1;
            m_prev_step = step_req;
        end
    endtask

    vec_t tbl[$];
    int   valid_seen;
    int   sel;

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,     0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,     0, 0,2,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,     1, 4,1,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,     0, 4,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,     0, 4,1,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,     0, 4,2,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,     1, 8,1,0,0,2));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     0, 8,0,0,0,2));
        tbl.push_back(mk(0,1,0,0,1,0,0, -8,0,    1, 0,0,0,0,3));
        tbl.push_back(mk(0,1,0,0,0,1,0, 12,0,    1,12,0,0,0,4));
        tbl.push_back(mk(0,1,0,0,0,0,1, 3,21,    1,24,0,0,0,5));
        tbl.push_back(mk(0,1,0,0,0,1,1, 0,4,     1, 4,0,0,0,6));
        tbl.push_back(mk(0,1,0,0,1,1,0, 4,0,     1, 8,0,0,0,7));
        tbl.push_back(mk(0,1,0,0,0,1,0, 2,0,     0, 8,3,1,0,7));
        tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,     0, 8,3,1,0,7));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,     0, 8,3,1,0,7));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,     0, 0,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1,0,0, 64,0,    0, 0,3,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,     0, 0,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     1, 4,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     1, 8,0,0,0,2));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     1,12,0,0,0,3));
        tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,     0,12,3,0,0,3));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     0,12,3,0,0,3));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,     0, 0,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,     0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0, 65,0,    0, 0,3,1,1,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].br,
                   tbl[i].jl, tbl[i].jr, tbl[i].imm, tbl[i].rs1);
            #1;
            chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
            @(posedge clk); #1;
            chk($sformatf("vec%0d.pc", i), pc, tbl[i].pc);
            chk($sformatf("vec%0d.state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d.misalign_err", i), 32'(misalign_err), 32'(tbl[i].mis));
            chk($sformatf("vec%0d.range_err", i), 32'(range_err), 32'(tbl[i].rng));
            chk($sformatf("vec%0d.retire_cnt", i), retire_cnt, tbl[i].cnt);
            @(negedge clk);
        end

        // Free-run from reset: one PAUSE cycle, then sequential fetch wrapping 60 -> 0
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("run%0d.instr_valid", k), 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("run%0d.pc", k), pc, (k == 1) ? 32'd0 : 32'(4 * ((k - 2) % 16)));
            @(negedge clk);
        end
        chk("run.retire_cnt", retire_cnt, 32'd19);
        chk("run.state", 32'(state), 32'd0);

        // Held step_req produces a single step per rising edge
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        valid_seen = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 10; k++) begin
                set_in(0, 0, (k < 5) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, 0);
                #1;
                if (instr_valid) valid_seen++;
                @(negedge clk);
            end
            chk($sformatf("step%0d.state", rep), 32'(state), 32'd1);
        end
        chk("step.valid_cycles", 32'(valid_seen), 32'd2);
        chk("step.pc", pc, 32'd8);
        chk("step.retire_cnt", retire_cnt, 32'd2);

        // Randomized run against the reference model
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        model_eval();
        @(posedge clk); model_clock(); @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            run_en   = ($urandom_range(0, 3) != 0);
            step_req = $urandom_range(0, 1);
            halt_req = ($urandom_range(0, 49) == 0);
            sel      = $urandom_range(0, 7);
            branch_take = (sel == 3) || (sel == 6);
            jal         = (sel == 4) || (sel == 6) || (sel == 7);
            jalr        = (sel == 5) || (sel == 7);
            if ($urandom_range(0, 9) < 8) begin
                imm     = 32'(4 * $urandom_range(0, 15)) - m_pc;
                rs1_val = m_pc + 32'($urandom_range(0, 1));
            end else begin
                imm     = 32'($urandom_range(0, 200)) - 32'd100;
                rs1_val = $urandom;
            end
            #1;
            model_eval();
            chk("rnd.instr_valid", 32'(instr_valid), 32'(e_valid));
            chk("rnd.pc", pc, m_pc);
            chk("rnd.pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("rnd.rom_addr", 32'(rom_addr), (m_pc / 4) % 128);
            chk("rnd.state", 32'(state), 32'(m_state));
            chk("rnd.misalign_err", 32'(misalign_err), 32'(m_mis));
            chk("rnd.range_err", 32'(range_err), 32'(m_rng));
            chk("rnd.retire_cnt", retire_cnt, m_cnt);
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
